// File: rtl/nvmem_mon_pkg.sv
// rtl/nvmem_mon_pkg.sv - shared types and defaults for the NV-memory write-rate monitor
//
// Purpose: monitor FSM state encoding, region-index type and the default
// region map (region 0 = 16'hE000..16'hEFFF, region 1 = 16'hF000..16'hFFFF).
// Ports: none (package).
// Optional feature macro used by the importing files: NVMEM_MON_SLIDING_EN.

package nvmem_mon_pkg;

  localparam logic [0:0] ST_MONITOR = 1'b0;
  localparam logic [0:0] ST_HOLD    = 1'b1;

  typedef enum logic [0:0] {
    MONITOR = ST_MONITOR,
    HOLD    = ST_HOLD
  } mon_state_t;

  // Wide enough for the largest supported region count (8).
  typedef logic [2:0] region_idx_t;

  localparam int unsigned MAX_REGIONS = 8;

  localparam logic [31:0] DEF_REGION_BASE  = {16'hF000, 16'hE000};
  localparam logic [31:0] DEF_REGION_LIMIT = {16'hFFFF, 16'hEFFF};

endpackage

// File: rtl/nvmem_region_counter.sv
// rtl/nvmem_region_counter.sv - per-region saturating write counter with optional previous-window bucket
//
// Purpose: counts writes to one address region within the current window.
// Optional macro NVMEM_MON_SLIDING_EN adds a prev bucket holding the count
// of the previous window; the effective count then becomes cnt + prev.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset
//   inc      in  one write to this region in the current cycle
//   roll     in  window boundary: move count into prev, clear count
//   clr      in  clear count and prev (monitor trip)
//   eff_next out effective count including this cycle's write (CNT_W+1 bits)

module nvmem_region_counter
  import nvmem_mon_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             roll,
  input  logic             clr,
  output logic [CNT_W:0]   eff_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Saturate instead of wrapping so a flood of writes can never look small.
  always_comb begin
    cnt_next = cnt;
    if (inc && (cnt != CNT_MAX)) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (roll) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

`ifdef NVMEM_MON_SLIDING_EN
  logic [CNT_W-1:0] prev;

  // A write in the boundary cycle belongs to the ending window, so prev
  // takes cnt_next rather than cnt.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prev <= '0;
    end else if (roll) begin
      prev <= cnt_next;
    end
  end

  assign eff_next = {1'b0, cnt_next} + {1'b0, prev};
`else
  assign eff_next = {1'b0, cnt_next};
`endif

endmodule

// File: rtl/nvmem_rate_monitor.sv
// rtl/nvmem_rate_monitor.sv - windowed per-region NV-memory write-rate monitor with reset request
//
// Purpose: counts data-memory writes per address region over fixed windows
// and requests a system reset for RESET_CYCLES cycles when any region
// reaches WRITE_THRESHOLD writes. Optional macro NVMEM_MON_SLIDING_EN
// enables the two-window sliding count (cnt + prev).
// Ports:
//   clk          in  clock, rising edge
//   rst          in  synchronous active-high reset
//   data_addr    in  data address, sampled when data_wen is high
//   data_wen     in  write enable, one write per high cycle
//   reset        out registered reset request
//   viol_region  out index of the region that caused the last trip (sticky)
//   window_tick  out high during the last cycle of each window

module nvmem_rate_monitor
  import nvmem_mon_pkg::*;
#(
  parameter int                            ADDR_W          = 16,
  parameter int                            NUM_REGIONS     = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE     = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT    = DEF_REGION_LIMIT,
  parameter int                            WRITE_THRESHOLD = 10,
  parameter int                            WINDOW_SIZE     = 2000,
  parameter int                            RESET_CYCLES    = 4,
  parameter int                            CNT_W           = 8,
  localparam int                           IDX_W           = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              data_wen,
  output logic              reset,
  output logic [IDX_W-1:0]  viol_region,
  output logic              window_tick
);

  localparam int WIN_W  = $clog2(WINDOW_SIZE);
  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [WIN_W-1:0]  LAST_WIN  = WIN_W'(WINDOW_SIZE - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W:0]    THRESH    = (CNT_W+1)'(WRITE_THRESHOLD);

  mon_state_t        state;
  mon_state_t        state_next;
  logic [WIN_W-1:0]  win_cnt;
  logic [WIN_W-1:0]  win_next;
  logic [HOLD_W-1:0] hold_cnt;

  logic [NUM_REGIONS-1:0] hit;
  logic [NUM_REGIONS-1:0] inc;
  logic [NUM_REGIONS-1:0] over;
  logic [CNT_W:0]         eff [NUM_REGIONS];
  logic                   matched;
  logic                   trip;
  logic [IDX_W-1:0]       trip_idx;
  logic                   boundary;
  logic                   roll;

  // Region decode: lowest matching index takes the write, others ignore it.
  always_comb begin
    hit      = '0;
    inc      = '0;
    over     = '0;
    matched  = 1'b0;
    trip_idx = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hit[i] = (data_addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
               (data_addr <= REGION_LIMIT[i*ADDR_W +: ADDR_W]);
      if (hit[i] && !matched) begin
        inc[i]  = data_wen && (state == MONITOR);
        matched = 1'b1;
      end
    end
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      over[i] = (state == MONITOR) && (eff[i] >= THRESH);
      if (over[i]) begin
        trip_idx = IDX_W'(i);
      end
    end
  end

  assign trip     = |over;
  assign boundary = (state == MONITOR) && (win_cnt == LAST_WIN);
  // A trip on the boundary cycle wins: counters are cleared, not rolled.
  assign roll     = boundary && !trip;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    nvmem_region_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc[g]),
      .roll     (roll),
      .clr      (trip),
      .eff_next (eff[g])
    );
  end

  always_comb begin
    if ((state == HOLD) || trip || boundary) begin
      win_next = '0;
    end else begin
      win_next = win_cnt + WIN_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      MONITOR: if (trip) state_next = HOLD;
      HOLD:    if (hold_cnt == LAST_HOLD) state_next = MONITOR;
      default: state_next = MONITOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MONITOR;
      hold_cnt    <= '0;
      win_cnt     <= '0;
      reset       <= 1'b0;
      window_tick <= 1'b0;
      viol_region <= '0;
    end else begin
      state       <= state_next;
      hold_cnt    <= ((state == HOLD) && (state_next == HOLD)) ? hold_cnt + HOLD_W'(1) : '0;
      win_cnt     <= win_next;
      reset       <= (state_next == HOLD);
      window_tick <= (win_next == LAST_WIN);
      if (trip) begin
        viol_region <= trip_idx;
      end
    end
  end

endmodule

// File: tb/tb_nvmem_rate_monitor.sv
// tb/tb_nvmem_rate_monitor.sv - self-checking bench for nvmem_rate_monitor

module tb_nvmem_rate_monitor;

`ifdef NVMEM_MON_SLIDING_EN
  localparam bit SLIDE = 1'b1;
`else
  localparam bit SLIDE = 1'b0;
`endif

  localparam int WS  = 2000;
  localparam int THR = 10;
  localparam int RC  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_addr = 16'h0;
  logic        data_wen = 1'b0;
  logic        reset;
  logic [0:0]  viol_region;
  logic        window_tick;

  logic        rst2 = 1'b1;
  logic [15:0] addr2 = 16'h0;
  logic        wen2 = 1'b0;
  logic        reset2;
  logic [0:0]  viol2;
  logic        tick2;

  always #5 clk = ~clk;

  nvmem_rate_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .data_addr   (data_addr),
    .data_wen    (data_wen),
    .reset       (reset),
    .viol_region (viol_region),
    .window_tick (window_tick)
  );

  nvmem_rate_monitor #(.WRITE_THRESHOLD(255)) dut255 (
    .clk         (clk),
    .rst         (rst2),
    .data_addr   (addr2),
    .data_wen    (wen2),
    .reset       (reset2),
    .viol_region (viol2),
    .window_tick (tick2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Behavioural reference: integer counts per region, a window position and
  // remaining hold cycles, stepped once per clock with that cycle's inputs.
  int m_hold = 0;
  int m_pos  = 0;
  int m_viol = 0;
  int m_cur [2];
  int m_prv [2];

  function automatic int region_of(input logic [15:0] a);
    if (a >= 16'hE000 && a <= 16'hEFFF) return 0;
    if (a >= 16'hF000) return 1;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic w, input logic [15:0] a);
    int rg;
    int hit;
    if (r) begin
      m_hold = 0; m_pos = 0; m_viol = 0;
      for (int i = 0; i < 2; i++) begin m_cur[i] = 0; m_prv[i] = 0; end
      return;
    end
    if (m_hold > 0) begin
      m_hold--;
      m_pos = 0;
      return;
    end
    rg = w ? region_of(a) : -1;
    if (rg >= 0) m_cur[rg] = (m_cur[rg] >= 255) ? 255 : m_cur[rg] + 1;
    hit = -1;
    for (int i = 1; i >= 0; i--)
      if (m_cur[i] + (SLIDE ? m_prv[i] : 0) >= THR) hit = i;
    if (hit >= 0) begin
      m_viol = hit;
      m_hold = RC;
      m_pos  = 0;
      for (int i = 0; i < 2; i++) begin m_cur[i] = 0; m_prv[i] = 0; end
    end else if (m_pos == WS - 1) begin
      for (int i = 0; i < 2; i++) begin m_prv[i] = m_cur[i]; m_cur[i] = 0; end
      m_pos = 0;
    end else begin
      m_pos++;
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic [15:0] a);
    rst = r; data_wen = w; data_addr = a;
    model_step(r, w, a);
    @(posedge clk); #1;
  endtask

  task automatic cyc2(input logic r, input logic w, input logic [15:0] a);
    rst2 = r; wen2 = w; addr2 = a;
    @(posedge clk); #1;
  endtask

  // Advance idle cycles until window_tick is seen; returns cycles taken or -1.
  task automatic wait_tick(output int n);
    n = -1;
    for (int k = 1; k <= WS + 100; k++) begin
      cyc(1'b0, 1'b0, 16'h0);
      if (window_tick === 1'b1) begin n = k; break; end
    end
  endtask

  typedef struct {
    logic        wen;
    logic [15:0] addr;
    logic        exp_reset;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int n;
    int first;
    int pulses;
    int any_reset;
    logic prev_r;
    logic [15:0] a;

    for (int i = 0; i < 15; i++) begin
      tbl[i].wen       = (i < 10);
      tbl[i].addr      = 16'hE000;
      tbl[i].exp_reset = (i >= 9 && i <= 12);
    end

    // Reset values
    cyc(1'b1, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 16'h0);
    chk("rst_reset", reset, 0);
    chk("rst_viol", viol_region, 0);
    chk("rst_tick", window_tick, 0);

    // 1: ninth write quiet, tenth write trips for exactly RC cycles
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, tbl[i].wen, tbl[i].addr);
      chk($sformatf("t1_reset_%0d", i), reset, tbl[i].exp_reset);
      chk($sformatf("t1_viol_%0d", i), viol_region, 0);
    end

    // 2: unmatched and split writes never trip
    cyc(1'b1, 1'b0, 16'h0);
    any_reset = 0;
    for (int i = 0; i < 30; i++) begin
      a = (i < 20) ? 16'hDFFF : (i < 25) ? 16'hE100 : 16'hF100;
      cyc(1'b0, 1'b1, a);
      if (reset !== 1'b0) any_reset++;
    end
    chk("t2_no_trip", any_reset, 0);

    // 3: 9 writes in window A, one early in window B
    cyc(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 16'hF000);
    chk("t3_quiet", reset, 0);
    wait_tick(n);
    chk("t3_tick_seen", n, WS - 10);
    cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 16'hF000);
    chk("t3_reset", reset, SLIDE ? 1 : 0);
    chk("t3_viol", viol_region, SLIDE ? 1 : 0);

    // 4: tenth write in the boundary cycle still trips; fresh window after
    cyc(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 16'hE000);
    wait_tick(n);
    chk("t4_tick_seen", n, WS - 10);
    cyc(1'b0, 1'b1, 16'hE000);
    chk("t4_trip", reset, 1);
    chk("t4_viol", viol_region, 0);
    for (int i = 0; i < RC - 1; i++) cyc(1'b0, 1'b0, 16'h0);
    chk("t4_hold_last", reset, 1);
    cyc(1'b0, 1'b0, 16'h0);
    chk("t4_release", reset, 0);
    n = -1;
    any_reset = 0;
    for (int k = 1; k <= WS + 100; k++) begin
      cyc(1'b0, k <= 9, 16'hE000);
      if (reset !== 1'b0) any_reset++;
      if (window_tick === 1'b1) begin n = k; break; end
    end
    chk("t4_window_restart", n, WS - 1);
    chk("t4_counts_cleared", any_reset, 0);

    // 5: rst during HOLD cycle 2
    cyc(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 16'hF000);
    chk("t5_trip", reset, 1);
    chk("t5_viol_set", viol_region, 1);
    cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 16'h0);
    chk("t5_reset_cleared", reset, 0);
    chk("t5_viol_cleared", viol_region, 0);
    any_reset = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b1, 16'hF000);
      if (reset !== 1'b0) any_reset++;
    end
    chk("t5_no_retrip", any_reset, 0);

    // 6: threshold 255 trips on the 255th write, no wrap afterwards
    cyc2(1'b1, 1'b0, 16'h0);
    cyc2(1'b1, 1'b0, 16'h0);
    first = -1;
    pulses = 0;
    prev_r = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      cyc2(1'b0, 1'b1, 16'hE000);
      if (reset2 === 1'b1 && prev_r !== 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      prev_r = reset2;
    end
    chk("t6_trip_index", first, 255);
    chk("t6_pulse_count", pulses, 1);
    chk("t6_viol", viol2, 0);

    // Random traffic against the reference model
    cyc(1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 8000; i++) begin
      logic r;
      logic w;
      r = ($urandom_range(0, 2999) == 0);
      w = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 3))
        0: a = 16'hE000 | 16'($urandom_range(0, 4095));
        1: a = 16'hF000 | 16'($urandom_range(0, 4095));
        2: a = 16'($urandom_range(0, 16'hDFFF));
        default: a = ($urandom_range(0, 1) == 0) ? 16'hEFFF : 16'hF000;
      endcase
      cyc(r, w, a);
      chk("rand_reset", reset, (m_hold > 0) ? 1 : 0);
      chk("rand_tick", window_tick, (m_hold == 0 && m_pos == WS - 1) ? 1 : 0);
      chk("rand_viol", viol_region, m_viol);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nvmem_rate_monitor.md
# nvmem_rate_monitor

Parametrised successor to the single-window NV-memory write monitor. It watches the data-memory write port and counts writes per address region over time windows. When any region reaches its write threshold, it asserts `reset` for a fixed number of cycles. It sits beside the CPU data bus, and `reset` feeds the system reset controller.

## Interface
- `ADDR_W`, 16: data address width.
- `NUM_REGIONS`, 2: number of monitored regions (1–8).
- `REGION_BASE`, {16'hF000, 16'hE000}: packed NUM_REGIONS×ADDR_W inclusive lower bounds; region 0 is in the LSBs.
- `REGION_LIMIT`, {16'hFFFF, 16'hEFFF}: packed NUM_REGIONS×ADDR_W inclusive upper bounds.
- `WRITE_THRESHOLD`, 10: write count that trips the monitor (≥1, < 2^CNT_W).
- `WINDOW_SIZE`, 2000: clock cycles per window (≥2).
- `RESET_CYCLES`, 4: length of the `reset` pulse in cycles (≥1).
- `CNT_W`, 8: per-region counter width.
- `clk` in 1: clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `data_addr` in ADDR_W: data address, sampled when `data_wen` is high.
- `data_wen` in 1: write enable, one write per high cycle.
- `reset` out 1: registered reset request to the system.
- `viol_region` out max(1,$clog2(NUM_REGIONS)): index of the region that caused the last trip; sticky.
- `window_tick` out 1: registered one-cycle pulse marking the last cycle of each window.

## Operation
- **Reset values** (`rst`): `reset`=0, `viol_region`=0, `window_tick`=0, state MONITOR, window counter 0, all region counters 0.
- **Window counter**: counts 0..WINDOW_SIZE-1 and wraps to 0. `window_tick` is high during the cycle in which the counter equals WINDOW_SIZE-1.
- **Region match**: a write matches when REGION_BASE[i] ≤ `data_addr` ≤ REGION_LIMIT[i]. On overlap, the lowest index wins. Each write increments at most one counter, and unmatched writes are ignored.
- **Region counter**: saturates at 2^CNT_W-1 with no wrap.
- **Window boundary**: at the end of the WINDOW_SIZE-1 cycle, each counter's value is copied to its `prev` bucket and the counter is cleared. A write in the boundary cycle counts toward the ending window.
- **Effective count**: `cnt`, or `cnt`+`prev` when sliding mode is enabled (see Configuration). Computed at CNT_W+1 bits and compared unsigned.
- **States**:
  - MONITOR: if any region's next effective count is ≥ WRITE_THRESHOLD, latch the lowest such index into `viol_region` and go to HOLD.
  - HOLD: `reset`=1; a hold counter runs 0..RESET_CYCLES-1. On entry, all `cnt` and `prev` buckets are cleared. Writes are ignored. The window counter is held at 0. At RESET_CYCLES-1, return to MONITOR.
- **Return to MONITOR**: the window counter restarts from 0 in the first MONITOR cycle.
- **`viol_region`**: cleared only by `rst`.

## Timing
- Trip latency is 1: the write sampled at edge n makes `reset` high from edge n+1 for exactly RESET_CYCLES cycles.
- `rst` overrides everything. If asserted during HOLD, `reset` is 0 after the next edge and all counters are 0.
- Multiple regions tripping in the same cycle produce one pulse, and `viol_region` reports the lowest index.
- When the trip happens in the boundary cycle, HOLD takes precedence and the `prev` copy is discarded.

## Configuration
- **`NVMEM_MON_SLIDING_EN` defined**: `prev` buckets are implemented and the effective count is `cnt`+`prev`. This gives a two-window sliding approximation.
- **Not defined**: no `prev` storage; the effective count is `cnt` only. This is pure fixed-window behaviour.

## Structure
- **Package `nvmem_mon_pkg`**: state enum (MONITOR, HOLD), the region-index typedef, and default base/limit constants.
- **Sub-module `nvmem_region_counter`**: one instance per region via generate. Holds `cnt`, optional `prev`, saturation logic and the effective-count output. Inputs are `inc`, `roll` and `clr`.
- **Top level**: holds the window counter, region decode/priority, the FSM and the output registers.

## Test plan
All scenarios use default parameters and RESET_CYCLES=4.
1. After `rst`, 9 writes to 16'hE000 within one window → `reset` stays 0. The 10th write → `reset`=1 from the next cycle for exactly 4 cycles, then 0, with `viol_region`=0.
2. 20 writes to 16'hDFFF, then 5 writes each to 16'hE100 and 16'hF100 → `reset` never asserts, because counts are per region.
3. 9 writes to 16'hF000 in window A, then 1 write early in window B:
   - without the macro, `reset` stays 0;
   - with NVMEM_MON_SLIDING_EN, `reset` asserts on that write and `viol_region`=1.
4. 10th write to 16'hE000 placed in the cycle where `window_tick`=1 → the trip still occurs, and after HOLD the window counter reads 0 and all counters read 0.
5. A trip followed by `rst` raised in HOLD cycle 2 → `reset`=0 after the next edge, `viol_region`=0, and 9 further writes do not trip.
6. 300 writes to 16'hE000 with WRITE_THRESHOLD=255 and CNT_W=8 → the trip fires at the 255th write with no counter wrap.
